// File: rtl/sudoku_board_writer.sv
// sudoku_board_writer: conditions the raw cursor buttons and write switch,
// tracks the cursor on the 4x4 board and issues one-cycle board-write
// commands, refusing protected cells and out-of-range digits.
//
// Write FSM states:
//   state      | meaning
//   S_IDLE     | waiting for a write-switch press
//   S_WRITE    | wrEn asserted for this single cycle with captured addr/data
//   S_WAIT_REL | waiting for the debounced write switch to drop
module sudoku_board_writer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       upButton,
  input  logic       downButton,
  input  logic       leftButton,
  input  logic       rightButton,
  input  logic       writeSwitch,
  input  logic [3:0] userNum,
  input  logic [15:0] protMask,
  output logic [1:0] cursorRow,
  output logic [1:0] cursorCol,
  output logic       wrEn,
  output logic [3:0] wrAddr,
  output logic [3:0] wrData,
  output logic       wpInd,
  output logic       errInd
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);

  // Channel index: 0 up, 1 down, 2 left, 3 right, 4 write switch.
  logic [4:0]       raw;
  logic [4:0]       sync1_q, sync1_d;
  logic [4:0]       sync2_q, sync2_d;
  logic [4:0]       deb_q, deb_d;
  logic [4:0]       deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [4:0]       press;

  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       move;
  logic [3:0] cur_addr;

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d;
  logic       wp_q, wp_d;

  assign raw      = {writeSwitch, rightButton, leftButton, downButton, upButton};
  assign press    = deb_q & ~deb_prev_q;
  assign cur_addr = {row_q, col_q};

  // Synchronize and debounce the five raw inputs; the counter only runs
  // while the synchronized level disagrees with the debounced one.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_CNT) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Cursor movement, wrap-around, one move per cycle with up > down > left > right.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    move  = |press[3:0];
    if (press[0])      row_d = row_q - 2'd1;
    else if (press[1]) row_d = row_q + 2'd1;
    else if (press[2]) col_d = col_q - 2'd1;
    else if (press[3]) col_d = col_q + 2'd1;
  end

  // Write FSM next state, capture of write command and error flag.
  // Address is captured from the cursor before any same-cycle move lands.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    wp_d    = protMask[cur_addr];
    if (move) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[4]) begin
          if (protMask[cur_addr] || (userNum > 4'd4)) begin
            err_d   = 1'b1;
            state_d = S_WAIT_REL;
          end else begin
            addr_d  = cur_addr;
            data_d  = userNum;
            err_d   = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE:    state_d = S_WAIT_REL;
      S_WAIT_REL: if (!deb_q[4]) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      row_q      <= '0;
      col_q      <= '0;
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      wp_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      row_q      <= row_d;
      col_q      <= col_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      wp_q       <= wp_d;
    end
  end

  assign cursorRow = row_q;
  assign cursorCol = col_q;
  assign wrEn      = (state_q == S_WRITE);
  assign wrAddr    = addr_q;
  assign wrData    = data_q;
  assign wpInd     = wp_q;
  assign errInd    = err_q;

endmodule

// File: tb/tb_sudoku_board_writer.sv
// Directed bench for sudoku_board_writer with DEBOUNCE_CYCLES = 4.
module tb_sudoku_board_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  btn = '0;   // 0 up, 1 down, 2 left, 3 right, 4 write switch
  logic [3:0]  userNum = '0;
  logic [15:0] protMask = '0;
  logic [1:0]  cursorRow, cursorCol;
  logic        wrEn, wpInd, errInd;
  logic [3:0]  wrAddr, wrData;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  logic [3:0] last_addr = '0;
  logic [3:0] last_data = '0;

  sudoku_board_writer #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .CLK(CLK), .RST(RST),
    .upButton(btn[0]), .downButton(btn[1]), .leftButton(btn[2]),
    .rightButton(btn[3]), .writeSwitch(btn[4]),
    .userNum(userNum), .protMask(protMask),
    .cursorRow(cursorRow), .cursorCol(cursorCol),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wpInd(wpInd), .errInd(errInd)
  );

  always #5 CLK = ~CLK;

  // Record every write strobe seen on the board side.
  always @(negedge CLK) begin
    if (wrEn) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = wrAddr;
      last_data = wrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    tick(8);
    btn = '0;
    tick(10);
  endtask

  initial begin
    tick(2);
    check("rst_row", cursorRow, 0);
    check("rst_col", cursorCol, 0);
    check("rst_wren", wrEn, 0);
    check("rst_wraddr", wrAddr, 0);
    check("rst_wrdata", wrData, 0);
    check("rst_wp", wpInd, 0);
    check("rst_err", errInd, 0);
    RST = 1'b1;
    tick(2);

    // Cursor movement and wrap-around.
    press(5'b01000); press(5'b01000); press(5'b01000);
    press(5'b00010);
    check("mv_row_1", cursorRow, 1);
    check("mv_col_3", cursorCol, 3);
    press(5'b01000);
    check("wrap_col", cursorCol, 0);
    press(5'b00001);
    check("up_row0", cursorRow, 0);
    press(5'b00001); press(5'b00001);
    check("wrap_row", cursorRow, 2);
    press(5'b01000);
    check("at_21", {cursorRow, cursorCol}, 4'd9);

    // Held write switch: exactly one write, exact latency.
    userNum = 4'd3;
    btn = 5'b10000;
    tick(7);
    check("wr_early", wrEn, 0);
    tick(1);
    check("wr_strobe", wrEn, 1);
    check("wr_addr", wrAddr, 9);
    check("wr_data", wrData, 3);
    tick(1);
    check("wr_one_cyc", wrEn, 0);
    check("wr_hold_addr", wrAddr, 9);
    tick(41);
    check("wr_held_cnt", wr_cnt, 1);
    btn = '0;
    tick(10);
    check("wr_rel_cnt", wr_cnt, 1);
    press(5'b10000);
    check("wr_again_cnt", wr_cnt, 2);

    // Protected cell: wpInd latency, rejected write, clear on move.
    protMask = 16'h0020;
    btn = 5'b00001;
    tick(7);
    check("mv_lat_old", cursorRow, 2);
    tick(1);
    check("mv_lat_new", cursorRow, 1);
    check("wp_lat_old", wpInd, 0);
    tick(1);
    check("wp_lat_new", wpInd, 1);
    btn = '0;
    tick(10);
    press(5'b10000);
    check("prot_nowr", wr_cnt, 2);
    check("prot_err", errInd, 1);
    press(5'b00100);
    check("prot_mv_col", cursorCol, 0);
    check("prot_err_clr", errInd, 0);
    check("prot_wp_clr", wpInd, 0);

    // Out-of-range digit, then a clear write.
    userNum = 4'd7;
    press(5'b10000);
    check("bad_nowr", wr_cnt, 2);
    check("bad_err", errInd, 1);
    userNum = 4'd0;
    press(5'b10000);
    check("clr_cnt", wr_cnt, 3);
    check("clr_addr", last_addr, 4);
    check("clr_data", last_data, 0);
    check("clr_err", errInd, 0);

    // Simultaneous presses and a short glitch.
    press(5'b00001);
    check("to_00", {cursorRow, cursorCol}, 4'd0);
    press(5'b01001);
    check("prio_pos", {cursorRow, cursorCol}, 4'd12);
    btn = 5'b00100;
    tick(2);
    btn = '0;
    tick(12);
    check("glitch_pos", {cursorRow, cursorCol}, 4'd12);

    // Async reset while waiting for release, switch still held afterwards.
    press(5'b00100);
    check("to_33", {cursorRow, cursorCol}, 4'd15);
    btn = 5'b10000;
    tick(12);
    check("w33_cnt", wr_cnt, 4);
    check("w33_addr", last_addr, 15);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("arst_pos", {cursorRow, cursorCol}, 4'd0);
    check("arst_wraddr", wrAddr, 0);
    check("arst_wp", wpInd, 0);
    check("arst_err", errInd, 0);
    check("arst_wren", wrEn, 0);
    tick(3);
    RST = 1'b1;
    tick(15);
    check("post_rst_cnt", wr_cnt, 5);
    check("post_rst_addr", last_addr, 0);
    btn = '0;
    tick(10);
    check("post_rel_cnt", wr_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sudoku_board_writer.md
# sudoku_board_writer

Input-side controller for the Sudoku Master game: conditions the raw cursor buttons and write switch, tracks the cursor on the 4x4 board, and issues single-cycle board-write commands carrying the player's digit. It sits between the board I/O pins (userNum, up/down/left/right buttons, writeSwitch) and the board storage inside sudokuMasterTop. It refuses writes to protected (given) cells or with out-of-range digits, and drives the write-protect indicator.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a debounced level changes. Use 4 in simulation and ~500000 on the board; valid range ≥1.
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES.
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- upButton, downButton, leftButton, rightButton  input  1 each  raw active-high buttons, asynchronous to CLK.
- writeSwitch  input  1  raw active-high write request, asynchronous.
- userNum  input  4  digit to write; 0 = clear, 1–4 = digit, 5–15 = invalid.
- protMask  input  16  bit (row*4+col) = 1 marks a protected cell.
- cursorRow, cursorCol  output  2 each  current cursor position, registered.
- wrEn  output  1  one-cycle board write strobe.
- wrAddr  output  4  cell address, row*4+col, valid with wrEn.
- wrData  output  4  digit, valid with wrEn.
- wpInd  output  1  registered; 1 when the cursor cell is protected.
- errInd  output  1  registered; 1 after a rejected write until the next accepted write or cursor move.

## Operation
- Five identical input channels (4 buttons + writeSwitch). Each channel has:
  - a 2-FF synchronizer;
  - a debounce counter that resets whenever the synchronized level equals the debounced level, and increments otherwise;
  - when the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears;
  - a press pulse on each 0→1 transition of the debounced level (one cycle).
- Cursor moves on press pulses, all modulo 4 (wrap-around):
  - up: row−1; down: row+1; left: col−1; right: col+1.
  - Example: up from row 0 gives row 3; right from col 3 gives col 0.
- Simultaneous press pulses in one cycle: only the highest-priority pulse is applied (up > down > left > right); the others are discarded.
- Write FSM states: IDLE, WRITE, WAIT_REL.
  - IDLE, writeSwitch press pulse: capture addr = {cursorRow, cursorCol} and data = userNum in the same cycle.
    - If protMask[addr] = 1 or userNum > 4: set errInd = 1, go to WAIT_REL, no write.
    - Otherwise: go to WRITE.
  - WRITE: wrEn = 1 with the captured wrAddr/wrData for exactly one cycle, errInd cleared, then go to WAIT_REL.
  - WAIT_REL: wait until the debounced writeSwitch = 0, then go to IDLE.
  - Holding the switch therefore yields exactly one write attempt.
- Cursor moves are applied in every FSM state. A move does not change an already-captured wrAddr.
- errInd clears on any applied cursor move or accepted write.
- wpInd is registered from protMask[{cursorRow, cursorCol}] every cycle. It tracks protMask changes with 1-cycle latency.
- wrAddr and wrData hold their last values when wrEn = 0.

## Timing
- Reset values (RST low, asynchronous):
  - cursorRow = 0, cursorCol = 0;
  - wrEn = 0, wrAddr = 0, wrData = 0;
  - wpInd = 0, errInd = 0;
  - FSM = IDLE;
  - all synchronizers, debounced levels and counters = 0.
- Reset deasserted mid-operation: no write or move is pending. A switch already held high at release produces one press after debounce.
- Button latency, with the raw level stable from the first sampling edge E:
  - press pulse is high in the cycle after edge E+2+DEBOUNCE_CYCLES;
  - cursor is updated at the next edge (E+3+DEBOUNCE_CYCLES).
- Write latency: press pulse in cycle T, wrEn high in cycle T+1. errInd, for a rejection, is high from cycle T+1.
- wpInd follows a cursor change one cycle later.
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples produce no pulse.

## Test plan
- Reset, then press right 3 times and down 1 time (each held for DEBOUNCE_CYCLES+4 cycles) -> cursor (1,3). Press right once more -> (1,0) (wrap). Press up twice from row 0 -> row 2.
- Cursor at (2,1), userNum = 3, protMask = 0, hold writeSwitch for 50 cycles -> exactly one wrEn pulse with wrAddr = 9, wrData = 3. No second pulse until the switch is released and pressed again.
- protMask[5] = 1, cursor moved to (1,1) -> wpInd = 1 one cycle after the move. Write attempt -> no wrEn, errInd = 1. Move left -> errInd = 0, wpInd = 0.
- userNum = 7 with an unprotected cursor cell -> no wrEn, errInd = 1. Then userNum = 0 and a new press -> wrEn with wrData = 0, errInd = 0.
- upButton and rightButton pulsed together from (0,0) -> cursor (3,0) only. A 2-cycle glitch on leftButton -> no move.
- RST asserted low while in WAIT_REL with cursor (3,3) -> all outputs reset immediately, independent of CLK. After release, with writeSwitch still high -> one write at addr 0 after debounce.
